// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet II header parser.
package eth_pkg;

   localparam int HDR_BYTES = 14;
   localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

   typedef struct packed {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] ethertype;
   } eth_hdr_t;

   typedef enum logic [1:0] {
      HDR     = 2'd0,
      PAYLOAD = 2'd1,
      DROP    = 2'd2
   } parse_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI-Stream register stage; full throughput when the sink is always ready.
module axis_reg_slice #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
            out_last <= in_last;
         end
      end
   end

endmodule

// File: rtl/eth_header_parser.sv
// Strips the 14-byte Ethernet II header into sideband fields and forwards the payload.
// Define ETH_MAC_FILTER_EN to drop frames not addressed to LOCAL_MAC or broadcast.
//
// state   | meaning
// HDR     | shifting in header bytes, index 0..13
// PAYLOAD | forwarding payload bytes through the output register
// DROP    | discarding a filtered frame until tlast (ETH_MAC_FILTER_EN only)
module eth_header_parser
   import eth_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int HDR_BYTES  = 14,
   parameter int CNT_WIDTH  = 16
`ifdef ETH_MAC_FILTER_EN
   ,
   parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   output logic                  hdr_valid,
   output logic [47:0]           dst_mac,
   output logic [47:0]           src_mac,
   output logic [15:0]           ethertype,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic [CNT_WIDTH-1:0]  runt_cnt
);

   parse_state_e state, state_nxt;
   logic [3:0]   idx;
   logic [111:0] hdr_sr;
   eth_hdr_t     hdr_new;
   logic         s_hs;
   logic         hdr_done;
   logic         hdr_accept;
   logic         slice_in_valid;
   logic         slice_in_ready;

   // Header as it will look once the current byte is shifted in.
   assign hdr_new  = {hdr_sr[103:0], s_tdata};
   assign s_hs     = s_tvalid && s_tready;
   assign hdr_done = (state == HDR) && s_hs && (idx == 4'(HDR_BYTES - 1));

`ifdef ETH_MAC_FILTER_EN
   assign hdr_accept = (hdr_new.dst == LOCAL_MAC) || (hdr_new.dst == ETH_BCAST_MAC);
`else
   assign hdr_accept = 1'b1;
`endif

   always_comb begin
      state_nxt      = state;
      s_tready       = 1'b0;
      slice_in_valid = 1'b0;
      case (state)
         HDR: begin
            s_tready = 1'b1;
            if (hdr_done && !s_tlast) begin
`ifdef ETH_MAC_FILTER_EN
               state_nxt = hdr_accept ? PAYLOAD : DROP;
`else
               state_nxt = PAYLOAD;
`endif
            end
         end
         PAYLOAD: begin
            s_tready       = slice_in_ready;
            slice_in_valid = s_tvalid;
            if (s_hs && s_tlast) state_nxt = HDR;
         end
`ifdef ETH_MAC_FILTER_EN
         DROP: begin
            s_tready = 1'b1;
            if (s_tvalid && s_tlast) state_nxt = HDR;
         end
`endif
         default: state_nxt = HDR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HDR;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         hdr_sr    <= '0;
         hdr_valid <= 1'b0;
         dst_mac   <= '0;
         src_mac   <= '0;
         ethertype <= '0;
         frame_cnt <= '0;
         runt_cnt  <= '0;
      end else begin
         hdr_valid <= 1'b0;
         if (state == HDR && s_hs) begin
            hdr_sr <= hdr_new;
            if (hdr_done) begin
               idx <= '0;
               if (hdr_accept) begin
                  dst_mac   <= hdr_new.dst;
                  src_mac   <= hdr_new.src;
                  ethertype <= hdr_new.ethertype;
                  hdr_valid <= 1'b1;
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end else if (s_tlast) begin
               idx      <= '0;
               runt_cnt <= runt_cnt + 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   axis_reg_slice #(.DATA_WIDTH(DATA_WIDTH)) u_out_slice (
      .clk       (clk),
      .rst       (rst),
      .in_data   (s_tdata),
      .in_valid  (slice_in_valid),
      .in_last   (s_tlast),
      .in_ready  (slice_in_ready),
      .out_data  (m_tdata),
      .out_valid (m_tvalid),
      .out_last  (m_tlast),
      .out_ready (m_tready)
   );

endmodule

// File: tb/tb_eth_header_parser.sv
// Randomized bench for eth_header_parser against a frame-level reference model.
module tb_eth_header_parser;

   localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready;
   logic        hdr_valid;
   logic [47:0] dst_mac;
   logic [47:0] src_mac;
   logic [15:0] ethertype;
   logic [15:0] frame_cnt;
   logic [15:0] runt_cnt;

   eth_header_parser dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .hdr_valid(hdr_valid), .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
      .frame_cnt(frame_cnt), .runt_cnt(runt_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   int           total = 0;
   int           bad = 0;
   beat_t        exp_q[$];
   logic [111:0] hdr_q[$];
   logic [7:0]   frm[$];
   int           exp_frame = 0;
   int           exp_runt = 0;
   int           hv_count = 0;
   int           beat_count = 0;
   logic [7:0]   last_data = 8'h00;
   int           rdy_mode = 0;
   logic         stall_prev = 1'b0;
   logic [7:0]   sv_data;
   logic         sv_last;

   task automatic chk(input string nm, input logic [111:0] act, input logic [111:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_event(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got unexpected event expected none", nm);
   endtask

   // Reference model: a whole frame's expected effect, from the frame bytes alone.
   task automatic model_frame();
      int           n;
      logic [111:0] h;
      logic         fwd;
      beat_t        b;
      n = frm.size();
      if (n < 14) begin
         exp_runt++;
      end else begin
         h = '0;
         for (int i = 0; i < 14; i++) h = {h[103:0], frm[i]};
         fwd = 1'b1;
`ifdef ETH_MAC_FILTER_EN
         fwd = (h[111:64] == LOCAL_MAC) || (h[111:64] == 48'hFFFF_FFFF_FFFF);
`endif
         if (fwd) begin
            exp_frame++;
            hdr_q.push_back(h);
            for (int i = 14; i < n; i++) begin
               b.d = frm[i];
               b.l = (i == n - 1);
               exp_q.push_back(b);
            end
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      logic hs;
      int   guard;
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      hs = 1'b0;
      guard = 0;
      while (!hs) begin
         @(negedge clk);
         hs = s_tready;
         @(posedge clk);
         #1;
         guard++;
         if (guard > 1000) begin
            $display("FAIL s_tready_timeout: got 0 expected 1");
            $fatal(1, "upstream stalled");
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int gap_pct);
      int n;
      n = frm.size();
      model_frame();
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 99) < gap_pct) begin
            @(posedge clk);
            #1;
         end
         send_byte(frm[i], i == n - 1);
      end
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || hdr_q.size() != 0 || m_tvalid) && g < 2000) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (g >= 2000) fail_event("drain_timeout");
      repeat (3) @(posedge clk);
      #1;
      chk("frame_cnt_model", frame_cnt, 112'(exp_frame[15:0]));
      chk("runt_cnt_model", runt_cnt, 112'(exp_runt[15:0]));
   endtask

   task automatic build_a();
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(8'hFF);
      frm.push_back(8'h02);
      for (int i = 1; i <= 5; i++) frm.push_back(8'(i));
      frm.push_back(8'h08);
      frm.push_back(8'h00);
      for (int i = 0; i < 46; i++) frm.push_back(8'(i));
   endtask

   task automatic build_dst(input logic [47:0] dst, input int plen);
      logic [47:0] d;
      d = dst;
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(d[47 - 8*i -: 8]);
      for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
      frm.push_back(8'h08);
      frm.push_back(8'h06);
      for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, sv_last, sv_data});
         stall_prev = m_tvalid && !m_tready;
         sv_data = m_tdata;
         sv_last = m_tlast;
         if (m_tvalid && m_tready) begin
            beat_count++;
            last_data = m_tdata;
            if (exp_q.size() == 0) fail_event("extra_beat");
            else begin
               e = exp_q.pop_front();
               chk("beat", {m_tlast, m_tdata}, {e.l, e.d});
            end
         end
         if (hdr_valid) begin
            hv_count++;
            if (hdr_q.size() == 0) fail_event("extra_hdr_valid");
            else chk("hdr_fields", {dst_mac, src_mac, ethertype}, hdr_q.pop_front());
         end
      end
   end

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      int hv0;
      rst = 1'b1;
      s_tdata = 8'h00;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_hdr_valid", hdr_valid, 0);
      chk("rst_fields", {dst_mac, src_mac, ethertype}, 0);
      chk("rst_counters", {frame_cnt, runt_cnt}, 0);
      chk("rst_m_data", {m_tlast, m_tdata}, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Broadcast frame, sink always ready.
      rdy_mode = 0;
      build_a();
      hv0 = hv_count;
      beat_count = 0;
      send_frame(0);
      wait_drain();
      chk("A_hv", 112'(hv_count - hv0), 1);
      chk("A_beats", 112'(beat_count), 46);
      chk("A_ethertype", ethertype, 16'h0800);
      chk("A_dst", dst_mac, 48'hFFFF_FFFF_FFFF);
      chk("A_src", src_mac, 48'h02_01_02_03_04_05);
      chk("A_last", last_data, 8'h2D);
      chk("A_frame_cnt", frame_cnt, 1);

      // Same frame, sink toggling ready.
      rdy_mode = 1;
      build_a();
      beat_count = 0;
      send_frame(0);
      wait_drain();
      chk("B_beats", 112'(beat_count), 46);
      chk("B_frame_cnt", frame_cnt, 2);

      // Runt then a good frame.
      rdy_mode = 0;
      frm.delete();
      for (int i = 0; i < 10; i++) frm.push_back(8'hA0 + 8'(i));
      hv0 = hv_count;
      beat_count = 0;
      send_frame(0);
      wait_drain();
      chk("runt_cnt", runt_cnt, 1);
      chk("runt_hv", 112'(hv_count - hv0), 0);
      chk("runt_beats", 112'(beat_count), 0);
      rdy_mode = 2;
      build_a();
      send_frame(30);
      wait_drain();
      chk("after_runt_frame_cnt", frame_cnt, 3);

      // Header-only frame, then a normal one.
      build_a();
      frm = frm[0:13];
      frm[12] = 8'h86;
      frm[13] = 8'hDD;
      hv0 = hv_count;
      beat_count = 0;
      send_frame(0);
      wait_drain();
      chk("hdronly_hv", 112'(hv_count - hv0), 1);
      chk("hdronly_beats", 112'(beat_count), 0);
      chk("hdronly_ethertype", ethertype, 16'h86DD);
      chk("hdronly_frame_cnt", frame_cnt, 4);
      build_dst(48'hFFFF_FFFF_FFFF, 30);
      send_frame(10);
      wait_drain();

      // Address filter cases.
      rdy_mode = 0;
      build_dst(48'h02_00_00_00_00_09, 6);
      hv0 = hv_count;
      beat_count = 0;
      send_frame(0);
      wait_drain();
`ifdef ETH_MAC_FILTER_EN
      chk("filt_other_beats", 112'(beat_count), 0);
      chk("filt_other_hv", 112'(hv_count - hv0), 0);
`else
      chk("filt_other_beats", 112'(beat_count), 6);
      chk("filt_other_hv", 112'(hv_count - hv0), 1);
`endif
      build_dst(LOCAL_MAC, 6);
      beat_count = 0;
      send_frame(0);
      wait_drain();
      chk("filt_local_beats", 112'(beat_count), 6);
      build_dst(48'hFFFF_FFFF_FFFF, 6);
      beat_count = 0;
      send_frame(0);
      wait_drain();
      chk("filt_bcast_beats", 112'(beat_count), 6);

      // Reset while the payload is in flight at byte 20.
      build_a();
      frm = frm[0:19];
      model_frame();
      for (int i = 0; i < 20; i++) send_byte(frm[i], 1'b0);
      rst = 1'b1;
      exp_q.delete();
      hdr_q.delete();
      exp_frame = 0;
      exp_runt = 0;
      #1;
      chk("midrst_m_tvalid", m_tvalid, 0);
      chk("midrst_fields", {dst_mac, src_mac, ethertype}, 0);
      chk("midrst_counters", {frame_cnt, runt_cnt}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      build_a();
      frm = frm[20:59];
      beat_count = 0;
      send_frame(0);
      wait_drain();
`ifdef ETH_MAC_FILTER_EN
      chk("tail_frame_cnt", frame_cnt, 0);
      chk("tail_beats", 112'(beat_count), 0);
`else
      chk("tail_frame_cnt", frame_cnt, 1);
      chk("tail_beats", 112'(beat_count), 26);
      chk("tail_ethertype", ethertype, 16'h1213);
      chk("tail_dst", dst_mac, 48'h06_07_08_09_0A_0B);
`endif

      // Randomized frames.
      rdy_mode = 2;
      for (int f = 0; f < 40; f++) begin
         int sel;
         int len;
         sel = $urandom_range(0, 3);
         case (sel)
            0:       build_dst(48'hFFFF_FFFF_FFFF, 0);
            1:       build_dst(LOCAL_MAC, 0);
            2:       build_dst(48'h02_00_00_00_00_09, 0);
            default: build_dst({$urandom, 16'($urandom)}, 0);
         endcase
         len = $urandom_range(0, 9) == 0 ? $urandom_range(1, 14) : $urandom_range(15, 70);
         while (frm.size() > len) void'(frm.pop_back());
         while (frm.size() < len) frm.push_back(8'($urandom));
         send_frame(20);
         if (f % 8 == 7) wait_drain();
      end
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
